// File: rtl/substantivo_note_tx.sv
// Note-word transmitter: emits a prefix, a class-defining final note and a 000 terminator as Ready-strobed symbols.
// Optional completed-word counter output Words is enabled by defining SUBST_TX_COUNT_EN.
module substantivo_note_tx #(
   parameter int unsigned GAP = 1
) (
   input  logic       clk,
   input  logic       Reset,
   input  logic       Start,
   input  logic [1:0] Tipo_In,
   input  logic [2:0] Len,
   output logic       Ready,
   output logic       Tom,
   output logic [2:0] Nota,
   output logic       Busy,
   output logic       End
`ifdef SUBST_TX_COUNT_EN
   ,output logic [3:0] Words
`endif
);

   typedef enum logic [2:0] {IDLE, PREFIX, FINAL, TERM, GAPW, DONE} state_t;

   localparam logic [3:0] GAP_M1 = 4'(GAP - 1);

   state_t     state_q, state_d;
   state_t     ret_q, ret_d;
   logic [1:0] tipo_q, tipo_d;
   logic [2:0] len_q, len_d;
   logic [2:0] idx_q, idx_d;
   logic [3:0] gap_q, gap_d;
   logic       ready_q, ready_d;
   logic       tom_q, tom_d;
   logic [2:0] nota_q, nota_d;
   logic       busy_q, busy_d;
   logic       end_q, end_d;

   logic       adv;
   logic       emit;
   state_t     follow;
   state_t     emit_st;
   logic [2:0] sym_idx;
   logic [1:0] sym_tipo;

   // Final note encodes the word class: {Tom, Nota}
   function automatic logic [3:0] final_sym(input logic [1:0] tipo);
      case (tipo)
         2'b11:   final_sym = {1'b0, 3'b011};
         2'b10:   final_sym = {1'b0, 3'b100};
         2'b01:   final_sym = {1'b0, 3'b101};
         default: final_sym = {1'b1, 3'b001};
      endcase
   endfunction

   always_comb begin
      state_d  = state_q;
      ret_d    = ret_q;
      tipo_d   = tipo_q;
      len_d    = len_q;
      idx_d    = idx_q;
      gap_d    = gap_q;
      ready_d  = 1'b0;
      tom_d    = tom_q;
      nota_d   = nota_q;
      busy_d   = busy_q;
      end_d    = 1'b0;
      adv      = 1'b0;
      emit     = 1'b0;
      follow   = IDLE;
      emit_st  = IDLE;
      sym_idx  = idx_q;
      sym_tipo = tipo_q;

      case (state_q)
         IDLE: begin
            tom_d  = 1'b0;
            nota_d = 3'b000;
            busy_d = 1'b0;
            if (Start) begin
               tipo_d   = Tipo_In;
               len_d    = Len;
               idx_d    = 3'd0;
               gap_d    = 4'd0;
               sym_idx  = 3'd0;
               sym_tipo = Tipo_In;
               emit     = 1'b1;
               emit_st  = (Len != 3'd0) ? PREFIX : FINAL;
            end
         end
         PREFIX: begin
            idx_d  = idx_q + 3'd1;
            adv    = 1'b1;
            follow = (({1'b0, idx_q} + 4'd1) < {1'b0, len_q}) ? PREFIX : FINAL;
         end
         FINAL: begin
            adv    = 1'b1;
            follow = TERM;
         end
         GAPW: begin
            if (gap_q == 4'd0) begin
               emit    = 1'b1;
               emit_st = ret_q;
            end else begin
               gap_d = gap_q - 4'd1;
            end
         end
         TERM: begin
            state_d = DONE;
            end_d   = 1'b1;
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            tom_d   = 1'b0;
            nota_d  = 3'b000;
         end
         default: state_d = IDLE;
      endcase

      // With no gap the following symbol is issued straight from the symbol state
      if (adv) begin
         if (GAP == 0) begin
            emit    = 1'b1;
            emit_st = follow;
            sym_idx = idx_d;
         end else begin
            state_d = GAPW;
            gap_d   = GAP_M1;
            ret_d   = follow;
         end
      end

      if (emit) begin
         state_d = emit_st;
         ready_d = 1'b1;
         busy_d  = 1'b1;
         case (emit_st)
            PREFIX: begin
               tom_d  = 1'b0;
               nota_d = sym_idx + 3'd1;
            end
            FINAL:   {tom_d, nota_d} = final_sym(sym_tipo);
            default: {tom_d, nota_d} = 4'b0000;
         endcase
      end
   end

`ifdef SUBST_TX_COUNT_EN
   logic [3:0] words_q, words_d;

   always_comb begin
      words_d = words_q;
      if (state_q == DONE) words_d = words_q + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (Reset) words_q <= '0;
      else       words_q <= words_d;
   end

   assign Words = words_q;
`endif

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q <= IDLE;
         ret_q   <= IDLE;
         tipo_q  <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         gap_q   <= '0;
         ready_q <= 1'b0;
         tom_q   <= 1'b0;
         nota_q  <= '0;
         busy_q  <= 1'b0;
         end_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         tipo_q  <= tipo_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         ready_q <= ready_d;
         tom_q   <= tom_d;
         nota_q  <= nota_d;
         busy_q  <= busy_d;
         end_q   <= end_d;
      end
   end

   assign Ready = ready_q;
   assign Tom   = tom_q;
   assign Nota  = nota_q;
   assign Busy  = busy_q;
   assign End   = end_q;

endmodule

// File: tb/tb_substantivo_note_tx.sv
// Scoreboard bench for substantivo_note_tx: one instance with GAP=1, one with GAP=0.
// Define SUBST_TX_COUNT_EN to also exercise the Words counter.
module tb_substantivo_note_tx;

   typedef struct {
      int         cyc;
      logic       tom;
      logic [2:0] nota;
   } sym_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   sym_t q1[$];
   sym_t q0[$];
   int   e1[$];
   int   e0[$];

   logic       Reset1 = 1'b1, Start1 = 1'b0;
   logic [1:0] Tipo1 = '0;
   logic [2:0] Len1 = '0;
   logic       Ready1, Tom1, Busy1, End1;
   logic [2:0] Nota1;

   logic       Reset0 = 1'b1, Start0 = 1'b0;
   logic [1:0] Tipo0 = '0;
   logic [2:0] Len0 = '0;
   logic       Ready0, Tom0, Busy0, End0;
   logic [2:0] Nota0;

`ifdef SUBST_TX_COUNT_EN
   logic [3:0] Words1, Words0;
`endif

   substantivo_note_tx #(.GAP(1)) dut (
      .clk(clk), .Reset(Reset1), .Start(Start1), .Tipo_In(Tipo1), .Len(Len1),
      .Ready(Ready1), .Tom(Tom1), .Nota(Nota1), .Busy(Busy1), .End(End1)
`ifdef SUBST_TX_COUNT_EN
      , .Words(Words1)
`endif
   );

   substantivo_note_tx #(.GAP(0)) dut0 (
      .clk(clk), .Reset(Reset0), .Start(Start0), .Tipo_In(Tipo0), .Len(Len0),
      .Ready(Ready0), .Tom(Tom0), .Nota(Nota0), .Busy(Busy0), .End(End0)
`ifdef SUBST_TX_COUNT_EN
      , .Words(Words0)
`endif
   );

   // Monitors: pop and compare whenever a DUT presents a strobe or End pulse
   always @(negedge clk) begin
      sym_t s;
      int   ec;
      if (Ready1 === 1'b1) begin
         n_tests++;
         if (q1.size() == 0) begin
            n_fail++;
            $display("FAIL g1_strobe: unexpected strobe at cycle %0d tom=%0b nota=%03b", cyc, Tom1, Nota1);
         end else begin
            s = q1.pop_front();
            if (cyc != s.cyc || Tom1 !== s.tom || Nota1 !== s.nota) begin
               n_fail++;
               $display("FAIL g1_strobe: got cyc=%0d tom=%0b nota=%03b, want cyc=%0d tom=%0b nota=%03b",
                        cyc, Tom1, Nota1, s.cyc, s.tom, s.nota);
            end
         end
      end
      if (End1 === 1'b1) begin
         n_tests++;
         if (e1.size() == 0) begin
            n_fail++;
            $display("FAIL g1_end: unexpected End at cycle %0d", cyc);
         end else begin
            ec = e1.pop_front();
            if (cyc != ec) begin
               n_fail++;
               $display("FAIL g1_end: got End at cycle %0d, want %0d", cyc, ec);
            end
         end
      end
      if (Ready0 === 1'b1) begin
         n_tests++;
         if (q0.size() == 0) begin
            n_fail++;
            $display("FAIL g0_strobe: unexpected strobe at cycle %0d tom=%0b nota=%03b", cyc, Tom0, Nota0);
         end else begin
            s = q0.pop_front();
            if (cyc != s.cyc || Tom0 !== s.tom || Nota0 !== s.nota) begin
               n_fail++;
               $display("FAIL g0_strobe: got cyc=%0d tom=%0b nota=%03b, want cyc=%0d tom=%0b nota=%03b",
                        cyc, Tom0, Nota0, s.cyc, s.tom, s.nota);
            end
         end
      end
      if (End0 === 1'b1) begin
         n_tests++;
         if (e0.size() == 0) begin
            n_fail++;
            $display("FAIL g0_end: unexpected End at cycle %0d", cyc);
         end else begin
            ec = e0.pop_front();
            if (cyc != ec) begin
               n_fail++;
               $display("FAIL g0_end: got End at cycle %0d, want %0d", cyc, ec);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_sym(input int inst, input int c, input logic tom, input logic [2:0] nota);
      sym_t s;
      s.cyc  = c;
      s.tom  = tom;
      s.nota = nota;
      if (inst == 1) q1.push_back(s);
      else           q0.push_back(s);
   endtask

   task automatic push_end(input int inst, input int c);
      if (inst == 1) e1.push_back(c);
      else           e0.push_back(c);
   endtask

   // Hand-written expected word: prefix 1..n, class note, terminator, End
   task automatic push_word(input int inst, input int t, input int g, input logic [1:0] tipo, input int n);
      logic       ft;
      logic [2:0] fn;
      for (int k = 0; k < n; k++) push_sym(inst, t + 1 + k * (g + 1), 1'b0, 3'(k + 1));
      case (tipo)
         2'b11:   begin ft = 1'b0; fn = 3'b011; end
         2'b10:   begin ft = 1'b0; fn = 3'b100; end
         2'b01:   begin ft = 1'b0; fn = 3'b101; end
         default: begin ft = 1'b1; fn = 3'b001; end
      endcase
      push_sym(inst, t + 1 + n * (g + 1), ft, fn);
      push_sym(inst, t + 1 + (n + 1) * (g + 1), 1'b0, 3'b000);
      push_end(inst, t + 2 + (n + 1) * (g + 1));
   endtask

   task automatic chk_idle1(input string name);
      chk({name, "_ready"}, int'(Ready1), 0);
      chk({name, "_tom"},   int'(Tom1),   0);
      chk({name, "_nota"},  int'(Nota1),  0);
      chk({name, "_busy"},  int'(Busy1),  0);
      chk({name, "_end"},   int'(End1),   0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      tick(); tick();
      chk_idle1("reset");
      chk("reset0_busy", int'(Busy0), 0);
      chk("reset0_nota", int'(Nota0), 0);
`ifdef SUBST_TX_COUNT_EN
      chk("reset_words", int'(Words1), 0);
`endif
      Reset1 = 1'b0;
      Reset0 = 1'b0;
      tick();

      // GAP=1, class 11, two prefix notes
      t = cyc;
      push_word(1, t, 1, 2'b11, 2);
      Tipo1 = 2'b11; Len1 = 3'd2; Start1 = 1'b1;
      tick();
      Start1 = 1'b0;
      chk("t1_busy_rise", int'(Busy1), 1);
      wait_to(t + 8);
      chk("t1_busy_end", int'(Busy1), 1);
      chk("t1_end_pulse", int'(End1), 1);
      wait_to(t + 9);
      chk("t1_busy_fall", int'(Busy1), 0);
      chk("t1_idle_nota", int'(Nota1), 0);
      wait_to(t + 12);

      // GAP=1, class 01, full prefix; Start with new class mid-word is ignored
      t = cyc;
      push_word(1, t, 1, 2'b01, 7);
      Tipo1 = 2'b01; Len1 = 3'd7; Start1 = 1'b1;
      tick();
      Start1 = 1'b0;
      wait_to(t + 3);
      Tipo1 = 2'b10; Len1 = 3'd3; Start1 = 1'b1;
      tick();
      Start1 = 1'b0;
      wait_to(t + 18);
      chk("t3_end_cycle", int'(End1), 1);
      wait_to(t + 30);
      chk("t3_no_second_word", int'(Busy1), 0);

      // GAP=0: unclassified empty word, then a class-10 word
      t = cyc;
      push_word(0, t, 0, 2'b00, 0);
      Tipo0 = 2'b00; Len0 = 3'd0; Start0 = 1'b1;
      tick();
      Start0 = 1'b0;
      wait_to(t + 3);
      chk("t2_end_cycle", int'(End0), 1);
      wait_to(t + 6);
      t = cyc;
      push_word(0, t, 0, 2'b10, 3);
      Tipo0 = 2'b10; Len0 = 3'd3; Start0 = 1'b1;
      tick();
      Start0 = 1'b0;
      wait_to(t + 10);

      // Reset on the cycle of the second prefix strobe aborts the word
      t = cyc;
      push_sym(1, t + 1, 1'b0, 3'b001);
      push_sym(1, t + 3, 1'b0, 3'b010);
      Tipo1 = 2'b11; Len1 = 3'd3; Start1 = 1'b1;
      tick();
      Start1 = 1'b0;
      wait_to(t + 3);
      Reset1 = 1'b1;
      tick();
      Reset1 = 1'b0;
      chk_idle1("abort");
      wait_to(t + 20);
      chk("abort_still_idle", int'(Busy1), 0);
      t = cyc;
      push_word(1, t, 1, 2'b10, 1);
      Tipo1 = 2'b10; Len1 = 3'd1; Start1 = 1'b1;
      tick();
      Start1 = 1'b0;
      wait_to(t + 6);
      chk("fresh_end_cycle", int'(End1), 1);
      wait_to(t + 9);

      // 17 back-to-back words with Start held high
      Reset1 = 1'b1;
      tick();
      Reset1 = 1'b0;
      t = cyc;
      for (int k = 0; k < 17; k++) push_word(1, t + 5 * k, 1, 2'b11, 0);
      Tipo1 = 2'b11; Len1 = 3'd0; Start1 = 1'b1;
      for (int m = 1; m <= 17; m++) begin
         wait_to(t + 5 * m - 4);
         if (m == 17) Start1 = 1'b0;
`ifdef SUBST_TX_COUNT_EN
         wait_to(t + 5 * m);
         chk($sformatf("words_after_%0d", m), int'(Words1), m % 16);
`endif
      end
      Start1 = 1'b0;
      wait_to(t + 95);
      chk("b2b_idle", int'(Busy1), 0);

      chk("q1_drained", q1.size(), 0);
      chk("e1_drained", e1.size(), 0);
      chk("q0_drained", q0.size(), 0);
      chk("e0_drained", e0.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
